// File: rtl/truth_table_checker_if.sv
// rtl/truth_table_checker_if.sv - vector handshake bundle between stimulus and checker
interface truth_table_checker_if;
  logic       vec_valid;
  logic [2:0] vec_abc;
  logic       vec_ready;

  modport master (output vec_valid, output vec_abc, input vec_ready);
  modport slave  (input vec_valid, input vec_abc, output vec_ready);
endinterface

// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - response checker for 3-in/3-out truth-table exercise blocks
module truth_table_checker #(
  parameter logic [7:0] EXP_X  = 8'hE0,
  parameter logic [7:0] EXP_AB = 8'hC0,
  parameter logic [7:0] EXP_AC = 8'hA0,
  parameter int         SETTLE = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  truth_table_checker_if.slave       vec_if,
  input  logic                       i_resp_x,
  input  logic                       i_resp_ab,
  input  logic                       i_resp_ac,
  output logic [7:0]                 o_covered,
  output logic [3:0]                 o_err_count,
  output logic [2:0]                 o_first_err_vec,
  output logic                       o_first_err_valid,
  output logic                       o_done,
  output logic                       o_pass
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Counter reaches zero SETTLE-1 cycles after loading, so the sample edge
  // lands SETTLE+1 edges after the handshake edge.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  logic [2:0] r_state;
  logic [2:0] r_abc;
  logic [3:0] r_cnt;
  logic [7:0] r_covered;
  logic [3:0] r_err_count;
  logic [2:0] r_first_err_vec;
  logic       r_first_err_valid;
  logic       r_done;
  logic       r_pass;

  logic       w_mismatch;
  logic [7:0] w_cov_next;
  logic [3:0] w_err_next;

  assign w_mismatch = (i_resp_x  != EXP_X[r_abc])  |
                      (i_resp_ab != EXP_AB[r_abc]) |
                      (i_resp_ac != EXP_AC[r_abc]);
  assign w_cov_next = r_covered | (8'b1 << r_abc);
  assign w_err_next = (w_mismatch && (r_err_count != 4'hF)) ? r_err_count + 4'd1 : r_err_count;

  // Ready is purely a function of state, so it drops the cycle after a handshake.
  assign vec_if.vec_ready = (r_state == S_ACCEPT);

  assign o_covered         = r_covered;
  assign o_err_count       = r_err_count;
  assign o_first_err_vec   = r_first_err_vec;
  assign o_first_err_valid = r_first_err_valid;
  assign o_done            = r_done;
  assign o_pass            = r_pass;

  // Control FSM and result registers; start overrides everything except reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_abc             <= 3'd0;
      r_cnt             <= 4'd0;
      r_covered         <= 8'd0;
      r_err_count       <= 4'd0;
      r_first_err_vec   <= 3'd0;
      r_first_err_valid <= 1'b0;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
    end else if (i_start) begin
      r_state           <= S_ACCEPT;
      r_covered         <= 8'd0;
      r_err_count       <= 4'd0;
      r_first_err_vec   <= 3'd0;
      r_first_err_valid <= 1'b0;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
    end else begin
      case (r_state)
        S_ACCEPT: begin
          if (vec_if.vec_valid) begin
            r_abc   <= vec_if.vec_abc;
            r_cnt   <= SETTLE_LOAD;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_SAMPLE: begin
          r_covered   <= w_cov_next;
          r_err_count <= w_err_next;
          if (w_mismatch && !r_first_err_valid) begin
            r_first_err_vec   <= r_abc;
            r_first_err_valid <= 1'b1;
          end
          if (w_cov_next == 8'hFF) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == 4'd0);
          end else begin
            r_state <= S_ACCEPT;
          end
        end
        S_IDLE, S_DONE: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - randomized self-checking bench for truth_table_checker
module tb_truth_table_checker;

  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       resp_x = 1'b0;
  logic       resp_ab = 1'b0;
  logic       resp_ac = 1'b0;
  logic [7:0] covered;
  logic [3:0] err_count;
  logic [2:0] first_err_vec;
  logic       first_err_valid;
  logic       done;
  logic       pass;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit [7:0] m_cov;
  int       m_err;
  bit [2:0] m_first;
  bit       m_first_valid;

  truth_table_checker_if u_if ();

  truth_table_checker #(
    .EXP_X(8'hE0), .EXP_AB(8'hC0), .EXP_AC(8'hA0), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .i_start(start), .vec_if(u_if),
    .i_resp_x(resp_x), .i_resp_ab(resp_ab), .i_resp_ac(resp_ac),
    .o_covered(covered), .o_err_count(err_count), .o_first_err_vec(first_err_vec),
    .o_first_err_valid(first_err_valid), .o_done(done), .o_pass(pass)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Correct block outputs {X,AB,AC} for inputs {A,B,C}
  function automatic logic [2:0] golden(input logic [2:0] v);
    logic a, b, c;
    a = v[2]; b = v[1]; c = v[0];
    return {(a & b) | (a & c), a & b, a & c};
  endfunction

  task automatic model_clear();
    m_cov = 8'h00; m_err = 0; m_first = 3'd0; m_first_valid = 1'b0;
  endtask

  task automatic model_apply(input logic [2:0] v, input bit mis);
    m_cov[v] = 1'b1;
    if (mis) begin
      if (m_err < 15) m_err++;
      if (!m_first_valid) begin
        m_first = v;
        m_first_valid = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    bit m_done;
    @(negedge clk);
    m_done = (m_cov == 8'hFF);
    chk({tag, ".covered"}, covered, m_cov);
    chk({tag, ".err_count"}, err_count, m_err);
    chk({tag, ".first_valid"}, first_err_valid, m_first_valid);
    if (m_first_valid) chk({tag, ".first_vec"}, first_err_vec, m_first);
    chk({tag, ".done"}, done, m_done);
    chk({tag, ".pass"}, pass, m_done && (m_err == 0));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
  endtask

  // Present one vector; 'early' corrupts responses before the sample edge,
  // 'samp' corrupts them at the sample edge only.
  task automatic send(input logic [2:0] v, input logic [2:0] early, input logic [2:0] samp);
    int n;
    @(negedge clk);
    n = 0;
    while (!u_if.vec_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!u_if.vec_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    u_if.vec_valid = 1'b1;
    u_if.vec_abc = v;
    {resp_x, resp_ab, resp_ac} = golden(v) ^ early;
    @(posedge clk);
    #1 u_if.vec_valid = 1'b0;
    for (int k = 0; k <= SETTLE; k++) begin
      @(negedge clk);
      chk("ready_low_after_hs", u_if.vec_ready, 0);
      if (k == SETTLE) {resp_x, resp_ab, resp_ac} = golden(v) ^ samp;
    end
    @(posedge clk);
    model_apply(v, samp != 3'b000);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    u_if.vec_valid = 1'b0;
    u_if.vec_abc = 3'd0;
    model_clear();

    // Reset state and IDLE ignores vectors
    do_reset();
    chk("rst.ready", u_if.vec_ready, 0);
    check_all("rst");
    u_if.vec_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle.ready", u_if.vec_ready, 0);
    end
    u_if.vec_valid = 1'b0;
    check_all("idle");

    // Golden sweep
    pulse_start();
    for (int v = 0; v < 8; v++) send(3'(v), 3'b000, 3'b000);
    check_all("golden");
    chk("golden.done_ready", u_if.vec_ready, 0);

    // Single fault: X wrong at 101
    pulse_start();
    for (int v = 0; v < 8; v++) send(3'(v), 3'b000, (v == 5) ? 3'b100 : 3'b000);
    check_all("single");

    // AB wrong at 011 then 110
    pulse_start();
    for (int v = 0; v < 8; v++) send(3'(v), 3'b000, (v == 3 || v == 6) ? 3'b010 : 3'b000);
    check_all("multi");

    // Settle window: wrong only before sample edge, then wrong at sample edge
    pulse_start();
    send(3'd1, 3'b111, 3'b000);
    check_all("settle_early");
    send(3'd2, 3'b000, 3'b001);
    check_all("settle_late");

    // Repeats and saturation
    pulse_start();
    for (int i = 0; i < 20; i++) send(3'd0, 3'b000, 3'b100);
    check_all("sat");
    for (int v = 1; v < 8; v++) send(3'(v), 3'b000, 3'b000);
    check_all("sat_done");

    // Randomized runs
    for (int r = 0; r < 4; r++) begin
      int guard;
      pulse_start();
      guard = 0;
      while (m_cov != 8'hFF && guard < 40) begin
        logic [2:0] fv;
        fv = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), fv);
        guard++;
      end
      check_all("random");
    end

    // Reset asserted during settle wait
    pulse_start();
    send(3'd0, 3'b000, 3'b000);
    send(3'd1, 3'b000, 3'b010);
    @(negedge clk);
    u_if.vec_valid = 1'b1;
    u_if.vec_abc = 3'd3;
    @(posedge clk);
    #1 u_if.vec_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_clear();
    chk("rstmid.covered", covered, 0);
    chk("rstmid.err", err_count, 0);
    chk("rstmid.first_valid", first_err_valid, 0);
    chk("rstmid.first_vec", first_err_vec, 0);
    chk("rstmid.done", done, 0);
    chk("rstmid.pass", pass, 0);
    chk("rstmid.ready", u_if.vec_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstmid.idle_ready", u_if.vec_ready, 0);

    // Abort mid-run with start colliding with a handshake
    pulse_start();
    for (int v = 0; v < 4; v++) send(3'(v), 3'b000, (v == 2) ? 3'b001 : 3'b000);
    @(negedge clk);
    start = 1'b1;
    u_if.vec_valid = 1'b1;
    u_if.vec_abc = 3'd5;
    {resp_x, resp_ab, resp_ac} = golden(3'd5);
    @(negedge clk);
    start = 1'b0;
    model_clear();
    chk("abort.covered", covered, 0);
    chk("abort.err", err_count, 0);
    chk("abort.ready", u_if.vec_ready, 1);
    @(posedge clk);
    #1 u_if.vec_valid = 1'b0;
    @(negedge clk);
    chk("abort.hs_taken", u_if.vec_ready, 0);
    repeat (SETTLE) @(negedge clk);
    @(posedge clk);
    model_apply(3'd5, 1'b0);
    check_all("abort_first");
    for (int v = 0; v < 8; v++) if (v != 5) send(3'(v), 3'b000, 3'b000);
    check_all("abort_done");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
